// File: rtl/mem_arb_pkg.sv
// Shared types, default depth and the out-of-range check for the two-requester SRAM arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef logic req_id_t;

   localparam int unsigned MEM_SIZE_DEF = 32'd4096;

   // A byte address is out of range when its word index reaches the array depth.
   function automatic logic is_oor(input logic [31:0] addr, input logic [31:0] mem_size);
      return ({2'b00, addr[31:2]} >= mem_size);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection; MEM_ARB_RR_EN selects round-robin, otherwise m0 has fixed priority.
import mem_arb_pkg::*;

module mem_arb_pick (
   input  logic    m0_valid,
   input  logic    m1_valid,
`ifdef MEM_ARB_RR_EN
   input  logic    last_gnt,
`endif
   output logic    any_valid,
   output req_id_t gnt
);

   // Grant decode: on a tie the round-robin build favours the requester not served last.
   always_comb begin
      any_valid = m0_valid | m1_valid;
      gnt       = 1'b0;
      if (m0_valid && m1_valid) begin
`ifdef MEM_ARB_RR_EN
         gnt = ~last_gnt;
`else
         gnt = 1'b0;
`endif
      end else if (m1_valid) begin
         gnt = 1'b1;
      end else begin
         gnt = 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two valid/ready requesters onto one synchronous-read SRAM port.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default: m0 fixed priority).
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_en,
   output logic [3:0]  s_we,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   output logic        oor
);

   state_t      state_r;
   req_id_t     gnt_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;

   logic        any_valid_s;
   req_id_t     pick_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic [3:0]  sel_wstrb_s;
   logic        sel_oor_s;

`ifdef MEM_ARB_RR_EN
   req_id_t     last_r;
`endif

   mem_arb_pick u_pick (
      .m0_valid  (m0_valid),
      .m1_valid  (m1_valid),
`ifdef MEM_ARB_RR_EN
      .last_gnt  (last_r),
`endif
      .any_valid (any_valid_s),
      .gnt       (pick_s)
   );

   // Request mux feeding the IDLE-state latch.
   always_comb begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_wstrb_s = m0_wstrb;
      if (pick_s == 1'b1) begin
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
         sel_wstrb_s = m1_wstrb;
      end else begin
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
         sel_wstrb_s = m0_wstrb;
      end
      sel_oor_s = is_oor(sel_addr_s, MEM_SIZE);
   end

   // Memory port is decoded from state so it drops the instant reset asserts.
   always_comb begin
      s_en    = (state_r == ACCESS);
      s_we    = s_en ? wstrb_r : 4'b0000;
      s_addr  = s_en ? {2'b00, addr_r[31:2]} : 32'd0;
      s_wdata = s_en ? wdata_r : 32'd0;
   end

   // Transaction FSM with registered completion outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r  <= IDLE;
         gnt_r    <= 1'b0;
         addr_r   <= 32'd0;
         wdata_r  <= 32'd0;
         wstrb_r  <= 4'b0000;
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         m0_rdata <= 32'd0;
         m1_rdata <= 32'd0;
         oor      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_r   <= 1'b1;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (any_valid_s) begin
                  gnt_r   <= pick_s;
                  addr_r  <= sel_addr_s;
                  wdata_r <= sel_wdata_s;
                  wstrb_r <= sel_wstrb_s;
`ifdef MEM_ARB_RR_EN
                  last_r  <= pick_s;
`endif
                  if (sel_oor_s) begin
                     // Out-of-range: skip the array and complete next cycle with zero data.
                     state_r  <= RESP;
                     m0_ready <= (pick_s == 1'b0);
                     m1_ready <= (pick_s == 1'b1);
                     oor      <= 1'b1;
                  end else begin
                     state_r <= ACCESS;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               state_r <= WAIT;
            end
            WAIT: begin
               state_r  <= RESP;
               m0_ready <= (gnt_r == 1'b0);
               m1_ready <= (gnt_r == 1'b1);
               m0_rdata <= ((gnt_r == 1'b0) && (wstrb_r == 4'b0000)) ? s_rdata : 32'd0;
               m1_rdata <= ((gnt_r == 1'b1) && (wstrb_r == 4'b0000)) ? s_rdata : 32'd0;
            end
            RESP: begin
               state_r  <= IDLE;
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
               m0_rdata <= 32'd0;
               m1_rdata <= 32'd0;
               oor      <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
               oor      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous-read SRAM.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_en;
   logic [3:0]  s_we;
   logic [31:0] s_addr, s_wdata;
   logic [31:0] s_rdata;
   logic        oor;

   logic [31:0] mem [0:4095];
   int          n_chk = 0;
   int          n_pass = 0;
   int          rdy_t [0:4];
   logic        rdy_id [0:4];
   int          n_rdy;

   mem_arbiter dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .oor(oor)
   );

   always #5 clk = ~clk;

   // SRAM model; preloads two words while reset is held.
   always @(posedge clk) begin
      if (!resetn) begin
         mem[5] <= 32'h1234_5678;
         mem[4] <= 32'h1122_3344;
      end else if (s_en) begin
         for (int b = 0; b < 4; b++)
            if (s_we[b]) mem[s_addr[11:0]][8*b +: 8] <= s_wdata[8*b +: 8];
         s_rdata <= mem[s_addr[11:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   initial begin
      resetn = 1'b0;
      m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
      m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
      repeat (3) tick();
      chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("rst_s_en", {31'd0, s_en}, 32'd0);
      chk("rst_oor", {31'd0, oor}, 32'd0);
      chk("rst_s_we", {28'd0, s_we}, 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      resetn = 1'b1;
      tick();

      // m0 read of word 5
      m0_valid = 1'b1; m0_addr = 32'h0000_0014; m0_wstrb = 4'd0;
      tick();
      chk("rd_s_en", {31'd0, s_en}, 32'd1);
      chk("rd_s_addr", s_addr, 32'd5);
      chk("rd_s_we", {28'd0, s_we}, 32'd0);
      chk("rd_early_ready", {31'd0, m0_ready}, 32'd0);
      tick();
      chk("rd_wait_s_en", {31'd0, s_en}, 32'd0);
      tick();
      chk("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
      chk("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("rd_oor", {31'd0, oor}, 32'd0);
      m0_valid = 1'b0;
      tick();
      chk("rd_ready_drop", {31'd0, m0_ready}, 32'd0);

      // m1 partial write to word 4
      m1_valid = 1'b1; m1_addr = 32'h0000_0010; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0101;
      tick();
      chk("wr_s_en", {31'd0, s_en}, 32'd1);
      chk("wr_s_we", {28'd0, s_we}, 32'h5);
      chk("wr_s_addr", s_addr, 32'd4);
      chk("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
      tick(); tick();
      chk("wr_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("wr_m1_rdata", m1_rdata, 32'd0);
      m1_valid = 1'b0; m1_wstrb = 4'd0;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0010;
      repeat (3) tick();
      chk("wr_readback", m0_rdata, 32'h11BB_33DD);
      m0_valid = 1'b0;
      tick();

      // out of range: word 16384, then the first word past the array (4096)
      m0_valid = 1'b1; m0_addr = 32'h0001_0000;
      tick();
      chk("oor_s_en", {31'd0, s_en}, 32'd0);
      chk("oor_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("oor_flag", {31'd0, oor}, 32'd1);
      chk("oor_rdata", m0_rdata, 32'd0);
      m0_addr = 32'h0000_4000;
      tick();
      chk("oor_clear", {31'd0, oor}, 32'd0);
      tick();
      chk("oor4096_flag", {31'd0, oor}, 32'd1);
      chk("oor4096_s_en", {31'd0, s_en}, 32'd0);
      m0_addr = 32'h0000_3FFC;
      tick(); tick();
      chk("last_word_s_en", {31'd0, s_en}, 32'd1);
      chk("last_word_s_addr", s_addr, 32'd4095);
      m0_valid = 1'b0;
      tick(); tick(); tick();

      // m1 arrives while m0 is in ACCESS
      m0_valid = 1'b1; m0_addr = 32'h0000_0014;
      tick();
      m1_valid = 1'b1; m1_addr = 32'h0000_0010; m1_wstrb = 4'd0;
      tick(); tick();
      chk("late_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("late_m1_idle", {31'd0, m1_ready}, 32'd0);
      m0_valid = 1'b0;
      tick();
      chk("late_idle_s_en", {31'd0, s_en}, 32'd0);
      tick();
      chk("late_m1_s_addr", s_addr, 32'd4);
      tick(); tick();
      chk("late_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("late_m1_rdata", m1_rdata, 32'h11BB_33DD);
      chk("late_m0_rdata", m0_rdata, 32'd0);
      m1_valid = 1'b0;
      tick();

      // both requesters held valid
      m0_valid = 1'b1; m0_addr = 32'h0000_0014;
      m1_valid = 1'b1; m1_addr = 32'h0000_0010;
      n_rdy = 0;
      for (int k = 1; k <= 19; k++) begin
         tick();
         if ((m0_ready || m1_ready) && n_rdy < 5) begin
            rdy_t[n_rdy] = k;
            rdy_id[n_rdy] = m1_ready;
            n_rdy++;
         end
         if (k == 15) m0_valid = 1'b0;
      end
      m1_valid = 1'b0;
      chk("both_count", n_rdy, 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("both_time%0d", i), rdy_t[i], 3 + 4 * i);
`ifdef MEM_ARB_RR_EN
         chk($sformatf("both_id%0d", i), {31'd0, rdy_id[i]}, (i % 2 == 1 || i == 4) ? 32'd1 : 32'd0);
`else
         chk($sformatf("both_id%0d", i), {31'd0, rdy_id[i]}, (i == 4) ? 32'd1 : 32'd0);
`endif
      end
      tick();

      // reset in WAIT, then a fresh m1 read
      m0_valid = 1'b1; m0_addr = 32'h0000_0014;
      tick(); tick();
      m0_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("rstw_ready", {31'd0, m0_ready}, 32'd0);
      chk("rstw_s_en", {31'd0, s_en}, 32'd0);
      chk("rstw_oor", {31'd0, oor}, 32'd0);
      tick();
      resetn = 1'b1;
      m1_valid = 1'b1; m1_addr = 32'h0000_0014;
      tick();
      chk("post_rst_s_en", {31'd0, s_en}, 32'd1);
      tick(); tick();
      chk("post_rst_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("post_rst_m1_rdata", m1_rdata, 32'h1234_5678);
      m1_valid = 1'b0;
      tick();

      // reset while ready is high
      m0_valid = 1'b1; m0_addr = 32'h0000_0014;
      repeat (3) tick();
      chk("rstr_pre_ready", {31'd0, m0_ready}, 32'd1);
      m0_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("rstr_ready", {31'd0, m0_ready}, 32'd0);
      chk("rstr_rdata", m0_rdata, 32'd0);
      tick();
      resetn = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port on-chip SRAM between the picorv32 native memory interface (requester 0) and a second bus master such as a DMA or debug loader (requester 1). Both requesters use the valid/ready/wstrb handshake of the core's memory bus. The arbiter serialises their transactions onto one synchronous-read memory port and rejects word addresses outside the array so that no requester ever hangs. It sits between the core and the memory array in `system`, replacing the direct core-to-memory connection.

## Interface
- `MEM_SIZE`, 4096: memory depth in 32-bit words; word address `addr>>2` must be `< MEM_SIZE`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_valid`, `m1_valid`  in  1  request pending; held until the matching ready.
- `m0_addr`, `m1_addr`  in  32  byte address; must be stable while valid.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte enables; 0 means read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid while the matching ready is high.
- `s_en`  out  1  memory access strobe.
- `s_we`  out  4  byte write enables; 0 means read.
- `s_addr`  out  32  word address (`addr>>2`).
- `s_wdata`  out  32  write data.
- `s_rdata`  in  32  read data, valid the cycle after `s_en`.
- `oor`  out  1  one-cycle pulse when an out-of-range request completes.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - When any valid is high, latch the grant id, address, wdata and wstrb into registers.
  - Next state is ACCESS for an in-range request, or RESP for an out-of-range request.
- ACCESS:
  - `s_en`=1 for exactly one cycle; `s_we`, `s_addr` and `s_wdata` come from the latched request.
  - Next state is WAIT.
- WAIT:
  - Capture `s_rdata` into the read-data register; the value is ignored for writes.
  - Next state is RESP.
- RESP:
  - Assert the granted `mN_ready` for one cycle.
  - The granted `mN_rdata` carries the captured word for an in-range read, and 0 for writes or out-of-range requests.
  - `oor`=1 in this cycle if the request was out of range.
  - Next state is IDLE.
- Out-of-range request: no memory access (`s_en` stays 0), writes are dropped, reads return 0.
- Arbitration happens only in IDLE. A valid that rises during a busy transaction waits; it is never lost.
- Only one request is in flight at a time. The non-granted ready stays 0 and its rdata is 0.
- Outputs are all registered, except `s_*`, which are decoded from registered state.

## Timing
- Reset values: state IDLE; `m0_ready`/`m1_ready`/`s_en`/`oor` = 0; `s_we` = 0; `s_addr`/`s_wdata`/`m0_rdata`/`m1_rdata` = 0; last-grant = 1.
- In-range latency: valid sampled at edge N, `s_en` high in cycle N+1, ready high in cycle N+3.
- Out-of-range latency: ready high in cycle N+1.
- Back-to-back throughput: one transaction per 4 cycles. IDLE re-arbitrates in the cycle after RESP.
- A requester must drop valid, or present a new request, in the cycle after its ready. Valid still high in IDLE is treated as a new request.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; `s_en` and ready drop asynchronously.
  - A write in ACCESS at the reset edge is not guaranteed; the requester reissues it.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. When both requesters are valid in IDLE, the one not granted last wins. Last-grant updates on every grant.
- Undefined: fixed priority; m0 always wins ties. The last-grant register is not built.
- Single-requester behaviour is identical in both modes.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - the requester-id type (1 bit);
  - the `MEM_SIZE` default;
  - the out-of-range compare helper.
- Sub-module `mem_arb_pick`: combinational grant selection from the two valids and last-grant, honouring `MEM_ARB_RR_EN`. The FSM stays in `mem_arbiter`.

## Test plan
- m0 read of word 5, memory holding 0x1234_5678 → `s_en` in cycle 1 with `s_addr`=5, `s_we`=0; `m0_ready` in cycle 3 with `m0_rdata`=0x1234_5678; `m1_ready` stays 0.
- m1 write to 0x0000_0010, wdata 0xAABB_CCDD, wstrb 0b0101 → `s_we`=0b0101 and `s_addr`=4 in ACCESS; a subsequent read returns bytes 0 and 2 updated only.
- Both valid continuously, RR enabled → grants alternate m0, m1, m0, m1; readies spaced 4 cycles apart. With the macro undefined, m1 is starved until m0 drops valid.
- m0 read at 0x0001_0000 (word 16384 ≥ 4096) → `s_en` never asserted; `m0_ready` and `oor` in cycle 1; `m0_rdata`=0.
- `resetn` pulled low in WAIT → ready, `s_en` and `oor` go 0 immediately. After release, a new m1 request completes normally in 3 cycles.
- m1 raises valid while an m0 transaction is in ACCESS → m1 is granted in the IDLE following m0's RESP; its ready comes 4 cycles after m0's ready.
